// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared constants, class and state encodings for the multi-byte decoder
// Purpose: opcode class constants, instruction class enum, FSM state enum,
//          ALU_OP and REG_ID field widths.
// Ports:   none (package).
package decoder_pkg;

    localparam int ALU_OP_LEN = 3;
    localparam int REG_ID_LEN = 3;

    // Opcode byte bits [6:4] for the fixed classes, and the F value they reserve.
    localparam logic [2:0] BR     = 3'b011;
    localparam logic [2:0] LDST   = 3'b111;
    localparam logic [1:0] F_LDST = 2'b11;

    typedef enum logic [1:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_BR,
        CLS_LDST
    } cls_t;

    typedef enum logic {
        S_OP,
        S_EXT
    } state_t;

endpackage

// File: rtl/instr_classify.sv
// rtl/instr_classify.sv - combinational opcode byte classifier
// Purpose: maps one opcode byte to its class, extension-byte need and the
//          fields that come from the opcode byte alone.
// Ports:   op        in   opcode byte
//          cls       out  instruction class
//          needs_ext out  opcode is followed by an extension byte
//          alu_op    out  ALU operation
//          imm_sel   out  operand B is the immediate
//          is_brn/is_brz/is_brp out branch condition flags
//          is_ld/is_st out load / store
//          addr_abs  out  load/store uses an absolute address
//          reg_id    out  register operand
//          imm_short out  short immediate nibble
module instr_classify
    import decoder_pkg::*;
(
    input  logic [7:0]            op,
    output cls_t                  cls,
    output logic                  needs_ext,
    output logic [ALU_OP_LEN-1:0] alu_op,
    output logic                  imm_sel,
    output logic                  is_brn,
    output logic                  is_brz,
    output logic                  is_brp,
    output logic                  is_ld,
    output logic                  is_st,
    output logic                  addr_abs,
    output logic [REG_ID_LEN-1:0] reg_id,
    output logic [3:0]            imm_short
);

    always_comb begin
        cls = CLS_ALU_R;
        if (op[6:4] == BR) begin
            cls = CLS_BR;
        end else if (op[6:4] == LDST) begin
            cls = CLS_LDST;
        end else if (op[6] && (op[5:4] != F_LDST)) begin
            cls = CLS_ALU_I;
        end
    end

    // Branches always carry a target byte; LD/ST and immediate ALU only when X is set.
    assign needs_ext = (cls == CLS_BR) ||
                       (op[7] && ((cls == CLS_LDST) || (cls == CLS_ALU_I)));

    assign alu_op    = {op[5:4], op[6] ? 1'b0 : op[3]};
    assign imm_sel   = (cls == CLS_ALU_I);
    assign is_brn    = (cls == CLS_BR) && op[3];
    assign is_brz    = (cls == CLS_BR) && op[2];
    assign is_brp    = (cls == CLS_BR) && op[1];
    assign is_ld     = (cls == CLS_LDST) && !op[3];
    assign is_st     = (cls == CLS_LDST) && op[3];
    assign addr_abs  = (cls == CLS_LDST) && op[7];
    assign reg_id    = op[2:0];
    assign imm_short = op[3:0];

endmodule

// File: rtl/decoder_mb.sv
// rtl/decoder_mb.sv - multi-byte instruction decoder between fetch and execute
// Purpose: takes instruction bytes from fetch, assembles one- or two-byte
//          instructions and presents each fully decoded instruction once.
// Ports:   CLK, RST (sync, active-high), FLUSH
//          INSTR/INSTR_VALID/INSTR_READY  byte stream from fetch
//          DEC_VALID/DEC_READY            decoded instruction handshake
//          ALU_OP, IMM, IMM_SEL, BR_TARGET, IS_BRN, IS_BRZ, IS_BRP,
//          IS_LD, IS_ST, ADDR_ABS, MEM_ADDR, REG_ID  registered decoded fields
module decoder_mb
    import decoder_pkg::*;
#(
    parameter int INSTR_LEN = 8,
    parameter int DATA_LEN  = 4,
    parameter int PC_LEN    = 7,
    parameter int ADDR_LEN  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FLUSH,
    input  logic [INSTR_LEN-1:0]  INSTR,
    input  logic                  INSTR_VALID,
    output logic                  INSTR_READY,
    output logic                  DEC_VALID,
    input  logic                  DEC_READY,
    output logic [ALU_OP_LEN-1:0] ALU_OP,
    output logic [DATA_LEN-1:0]   IMM,
    output logic                  IMM_SEL,
    output logic [PC_LEN-1:0]     BR_TARGET,
    output logic                  IS_BRN,
    output logic                  IS_BRZ,
    output logic                  IS_BRP,
    output logic                  IS_LD,
    output logic                  IS_ST,
    output logic                  ADDR_ABS,
    output logic [ADDR_LEN-1:0]   MEM_ADDR,
    output logic [REG_ID_LEN-1:0] REG_ID
);

    state_t                 state, state_nx;
    logic [7:0]             op_q;
    logic [7:0]             cls_in;
    logic [INSTR_LEN-1:0]   ext_byte;
    logic                   xfer, load_out, capture_op;

    cls_t                   c_cls;
    logic                   c_needs_ext, c_imm_sel;
    logic                   c_brn, c_brz, c_brp, c_ld, c_st, c_abs;
    logic [ALU_OP_LEN-1:0]  c_alu_op;
    logic [REG_ID_LEN-1:0]  c_reg_id;
    logic [3:0]             c_imm_short;

    // A new byte may enter whenever the output slot is free or being emptied.
    assign INSTR_READY = !DEC_VALID || DEC_READY;
    assign xfer        = INSTR_VALID && INSTR_READY;

    // While waiting for the extension byte the latched opcode drives the classifier.
    assign cls_in   = (state == S_EXT) ? op_q : INSTR[7:0];
    assign ext_byte = (state == S_EXT) ? INSTR : '0;

    instr_classify u_classify (
        .op        (cls_in),
        .cls       (c_cls),
        .needs_ext (c_needs_ext),
        .alu_op    (c_alu_op),
        .imm_sel   (c_imm_sel),
        .is_brn    (c_brn),
        .is_brz    (c_brz),
        .is_brp    (c_brp),
        .is_ld     (c_ld),
        .is_st     (c_st),
        .addr_abs  (c_abs),
        .reg_id    (c_reg_id),
        .imm_short (c_imm_short)
    );

    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            state <= S_OP;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_OP:    if (xfer && c_needs_ext) state_nx = S_EXT;
            S_EXT:   if (xfer) state_nx = S_OP;
            default: state_nx = S_OP;
        endcase
    end

    always_comb begin
        load_out   = 1'b0;
        capture_op = 1'b0;
        case (state)
            S_OP: begin
                capture_op = xfer && c_needs_ext;
                load_out   = xfer && !c_needs_ext;
            end
            S_EXT:   load_out = xfer;
            default: load_out = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q      <= '0;
            DEC_VALID <= 1'b0;
            ALU_OP    <= '0;
            IMM       <= '0;
            IMM_SEL   <= 1'b0;
            BR_TARGET <= '0;
            IS_BRN    <= 1'b0;
            IS_BRZ    <= 1'b0;
            IS_BRP    <= 1'b0;
            IS_LD     <= 1'b0;
            IS_ST     <= 1'b0;
            ADDR_ABS  <= 1'b0;
            MEM_ADDR  <= '0;
            REG_ID    <= '0;
        end else if (FLUSH) begin
            // Only the valid flag is cleared; data fields keep their last values.
            DEC_VALID <= 1'b0;
        end else begin
            if (capture_op) begin
                op_q <= INSTR[7:0];
            end
            if (load_out) begin
                DEC_VALID <= 1'b1;
                ALU_OP    <= c_alu_op;
                IMM       <= ((state == S_EXT) && (c_cls == CLS_ALU_I))
                             ? ext_byte[DATA_LEN-1:0] : DATA_LEN'(c_imm_short);
                IMM_SEL   <= c_imm_sel;
                BR_TARGET <= ext_byte[PC_LEN-1:0];
                IS_BRN    <= c_brn;
                IS_BRZ    <= c_brz;
                IS_BRP    <= c_brp;
                IS_LD     <= c_ld;
                IS_ST     <= c_st;
                ADDR_ABS  <= c_abs;
                MEM_ADDR  <= ext_byte[ADDR_LEN-1:0];
                REG_ID    <= c_reg_id;
            end else if (DEC_READY) begin
                DEC_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decoder_mb.sv
// tb/tb_decoder_mb.sv - self-checking bench for decoder_mb
module tb_decoder_mb;

    logic       clk = 1'b0;
    logic       rst, flush, instr_valid, dec_ready;
    logic [7:0] instr;
    logic       instr_ready, dec_valid;
    logic [2:0] alu_op;
    logic [7:0] imm;
    logic       imm_sel;
    logic [7:0] br_target;
    logic       is_brn, is_brz, is_brp, is_ld, is_st, addr_abs;
    logic [7:0] mem_addr;
    logic [2:0] reg_id;

    always #5 clk = ~clk;

    decoder_mb #(
        .INSTR_LEN (8),
        .DATA_LEN  (8),
        .PC_LEN    (8),
        .ADDR_LEN  (8)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .FLUSH       (flush),
        .INSTR       (instr),
        .INSTR_VALID (instr_valid),
        .INSTR_READY (instr_ready),
        .DEC_VALID   (dec_valid),
        .DEC_READY   (dec_ready),
        .ALU_OP      (alu_op),
        .IMM         (imm),
        .IMM_SEL     (imm_sel),
        .BR_TARGET   (br_target),
        .IS_BRN      (is_brn),
        .IS_BRZ      (is_brz),
        .IS_BRP      (is_brp),
        .IS_LD       (is_ld),
        .IS_ST       (is_st),
        .ADDR_ABS    (addr_abs),
        .MEM_ADDR    (mem_addr),
        .REG_ID      (reg_id)
    );

    typedef struct packed {
        logic [2:0] alu;
        logic [7:0] imm;
        logic       sel;
        logic [7:0] br;
        logic       n, z, p, ld, st, abs;
        logic [7:0] mem;
        logic [2:0] rid;
        logic       chk_imm, chk_br, chk_mem;
    } exp_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Instruction-level reference: what a complete instruction decodes to.
    function automatic bit two_bytes(input logic [7:0] op);
        // Branches always; otherwise X set on any I=1 encoding (imm ALU or LD/ST).
        return (op[6:4] == 3'd3) || (op[7] && op[6]);
    endfunction

    function automatic exp_t decode(input logic [7:0] op, input logic [7:0] ext);
        exp_t e;
        int   grp;
        e     = '0;
        grp   = int'(op[6:4]);
        e.rid = op[2:0];
        e.alu = {op[5:4], op[6] ? 1'b0 : op[3]};
        if (grp == 3) begin
            e.n = op[3]; e.z = op[2]; e.p = op[1];
            e.br = ext; e.chk_br = 1'b1;
        end else if (grp == 7) begin
            e.ld  = !op[3];
            e.st  = op[3];
            e.abs = op[7];
            if (op[7]) begin
                e.mem = ext; e.chk_mem = 1'b1;
            end
        end else if (op[6]) begin
            e.sel     = 1'b1;
            e.chk_imm = 1'b1;
            e.imm     = op[7] ? ext : {4'h0, op[3:0]};
        end
        return e;
    endfunction

    // Model state: one output slot plus an optional pending opcode.
    bit         m_init = 0;
    bit         m_valid, m_zero, m_have_op;
    logic [7:0] m_op;
    exp_t       m_out;
    int         n_decodes = 0;

    task automatic step(input bit iv, input logic [7:0] b, input bit dr,
                        input bit fl, input bit rs, output bit took);
        bit   rdy, xfer, done;
        exp_t nw;
        rst = rs; flush = fl; instr_valid = iv; instr = b; dec_ready = dr;
        @(negedge clk);
        rdy  = !m_valid || dr;
        took = 1'b0;
        if (m_init) begin
            check("instr_ready", instr_ready, rdy);
            check("dec_valid", dec_valid, m_valid);
            if (m_valid || m_zero) begin
                check("alu_op", alu_op, m_out.alu);
                check("imm_sel", imm_sel, m_out.sel);
                check("reg_id", reg_id, m_out.rid);
                check("br_flags", {is_brn, is_brz, is_brp}, {m_out.n, m_out.z, m_out.p});
                check("ldst_flags", {is_ld, is_st, addr_abs}, {m_out.ld, m_out.st, m_out.abs});
                if (m_zero || m_out.chk_imm) check("imm", imm, m_out.imm);
                if (m_zero || m_out.chk_br)  check("br_target", br_target, m_out.br);
                if (m_zero || m_out.chk_mem) check("mem_addr", mem_addr, m_out.mem);
            end
        end
        if (rs) begin
            m_init = 1; m_valid = 0; m_zero = 1; m_have_op = 0; m_out = '0;
        end else if (fl) begin
            m_valid = 0; m_have_op = 0;
        end else begin
            xfer = iv && rdy;
            done = 0;
            nw   = '0;
            took = xfer;
            if (m_valid && dr) n_decodes++;
            if (xfer) begin
                if (m_have_op) begin
                    nw = decode(m_op, b); done = 1; m_have_op = 0;
                end else if (two_bytes(b)) begin
                    m_op = b; m_have_op = 1;
                end else begin
                    nw = decode(b, 8'h00); done = 1;
                end
            end
            if (done) begin
                m_out = nw; m_valid = 1; m_zero = 0;
            end else if (dr) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit t;
        for (int i = 0; i < n; i++) step(0, 8'h00, 1, 0, 0, t);
    endtask

    initial begin
        bit         t;
        logic [7:0] cur;
        bit         iv, dr;

        rst = 1; flush = 0; instr_valid = 0; instr = 0; dec_ready = 1;
        @(posedge clk); #1;
        step(0, 8'h00, 1, 0, 1, t);
        step(0, 8'h00, 1, 0, 1, t);
        check("rst_dec_valid", dec_valid, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_imm", imm, 0);
        idle(1);

        // 1: short immediate
        step(1, 8'h45, 1, 0, 0, t);
        check("t1_valid", dec_valid, 1);
        check("t1_alu", alu_op, 3'b000);
        check("t1_sel", imm_sel, 1);
        check("t1_imm", imm, 8'h05);
        idle(2);

        // 2: branch needs its target byte before any decode
        step(1, 8'h38, 1, 0, 0, t);
        check("t2_no_valid", dec_valid, 0);
        step(1, 8'h5A, 1, 0, 0, t);
        check("t2_valid", dec_valid, 1);
        check("t2_flags", {is_brn, is_brz, is_brp}, 3'b100);
        check("t2_target", br_target, 8'h5A);
        idle(2);

        // 3: long immediate, then absolute load
        step(1, 8'hD2, 1, 0, 0, t);
        step(1, 8'hC3, 1, 0, 0, t);
        check("t3_alu", alu_op, 3'b010);
        check("t3_imm", imm, 8'hC3);
        step(1, 8'hF3, 1, 0, 0, t);
        step(1, 8'h80, 1, 0, 0, t);
        check("t3_ld", {is_ld, addr_abs}, 2'b11);
        check("t3_reg", reg_id, 3);
        check("t3_mem", mem_addr, 8'h80);
        idle(2);

        // 4: back-pressure holds the decode and blocks the next byte
        step(1, 8'h45, 1, 0, 0, t);
        for (int i = 0; i < 3; i++) begin
            step(1, 8'h0B, 0, 0, 0, t);
            check("t4_hold_ready", instr_ready, 0);
            check("t4_hold_imm", imm, 8'h05);
        end
        step(1, 8'h0B, 1, 0, 0, t);
        check("t4_alu", alu_op, 3'b001);
        check("t4_sel", imm_sel, 0);
        check("t4_reg", reg_id, 3);
        idle(2);

        // 5: flush drops a half-received branch and the byte presented with it
        step(1, 8'h38, 1, 0, 0, t);
        step(1, 8'h5A, 1, 1, 0, t);
        check("t5_flush_valid", dec_valid, 0);
        step(1, 8'h45, 1, 0, 0, t);
        check("t5_valid", dec_valid, 1);
        check("t5_not_br", {is_brn, is_brz, is_brp}, 3'b000);
        check("t5_imm", imm, 8'h05);
        idle(2);

        // 6: reset mid-instruction, then a sustained one-byte stream
        step(1, 8'h38, 1, 0, 0, t);
        step(1, 8'h5A, 1, 0, 1, t);
        check("t6_rst_valid", dec_valid, 0);
        check("t6_rst_alu", alu_op, 0);
        step(1, 8'h45, 1, 0, 0, t);
        check("t6_first", dec_valid, 1);
        step(1, 8'h22, 1, 0, 0, t);
        check("t6_second", dec_valid, 1);
        for (int i = 0; i < 8; i++) begin
            cur = {1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
            step(1, cur, 1, 0, 0, t);
            check("t6_stream", dec_valid, 1);
        end
        idle(2);

        // Random traffic with back-pressure, flushes and resets.
        cur = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4000; i++) begin
            iv = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                step(iv, cur, dr, 0, 1, t);
                cur = 8'($urandom_range(0, 255));
            end else if ($urandom_range(0, 59) == 0) begin
                step(iv, cur, dr, 1, 0, t);
                cur = 8'($urandom_range(0, 255));
            end else begin
                step(iv, cur, dr, 0, 0, t);
                if (t) cur = 8'($urandom_range(0, 255));
            end
        end
        idle(3);
        check("drained_valid", dec_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decoder_mb.md
Name: decoder_mb

Overview:
- Parametrised, multi-byte successor to the single-byte core decoder.
- Accepts the instruction stream one byte per handshake from fetch. Classifies the opcode byte and, where the opcode calls for it, consumes one extension byte carrying a branch target, a long immediate or an absolute load/store address.
- Presents one fully decoded instruction per output handshake to the execute stage.
- Sits between the fetch unit and the ALU/register file/branch unit.

Parameters:
- INSTR_LEN, 8, byte width of the instruction stream; must be ≥ 8.
- DATA_LEN, 4, datapath width; 4 ≤ DATA_LEN ≤ INSTR_LEN.
- PC_LEN, 7, program counter width; PC_LEN ≤ INSTR_LEN.
- ADDR_LEN, 8, data memory address width; ADDR_LEN ≤ INSTR_LEN.

Ports:
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high
- FLUSH  in  1  drop any partial or pending instruction
- INSTR  in  INSTR_LEN  instruction byte from fetch
- INSTR_VALID  in  1  INSTR is valid
- INSTR_READY  out  1  decoder accepts INSTR this cycle
- DEC_VALID  out  1  decoded fields valid
- DEC_READY  in  1  execute stage consumes the decoded instruction
- ALU_OP  out  3  ALU operation
- IMM  out  DATA_LEN  immediate operand
- IMM_SEL  out  1  operand B is IMM
- BR_TARGET  out  PC_LEN  branch target
- IS_BRN, IS_BRZ, IS_BRP  out  1 each  branch condition flags
- IS_LD, IS_ST  out  1 each  load / store
- ADDR_ABS  out  1  load/store uses MEM_ADDR rather than register-indirect addressing
- MEM_ADDR  out  ADDR_LEN  absolute address
- REG_ID  out  3  register operand

Behaviour:
- Opcode byte b fields: X = b[7] (extend), I = b[6], F = b[5:4], low nibble b[3:0].
- Classes:
  - Branch: b[6:4] = 011. N/Z/P = b[3]/b[2]/b[1]. Always two bytes; the extension byte is the target.
  - LD/ST: b[6:4] = 111. b[3] = 0 is LD, 1 is ST. REG_ID = b[2:0]. Two bytes if X = 1 (absolute address), else one byte.
  - Immediate ALU: I = 1 and F ≠ 11. Two bytes if X = 1 (long immediate), else one byte.
  - Register ALU: remaining encodings. One byte; X is ignored.
- ALU_OP = {F, I ? 0 : b[3]}. IMM_SEL = I for ALU classes, 0 for branch and LD/ST. REG_ID = b[2:0] for all classes.
- IMM: short form is the zero-extended b[3:0]; long form is ext[DATA_LEN-1:0].
- BR_TARGET = ext[PC_LEN-1:0]. MEM_ADDR = ext[ADDR_LEN-1:0].
- A branch with N = Z = P = 0 still consumes its target byte and decodes as a NOP (all branch flags 0).
- FSM states:
  - S_OP: awaiting an opcode byte.
  - S_EXT: awaiting an extension byte; the class and first-byte fields are latched.
- Transitions:
  - S_OP, single-byte opcode accepted → output register loaded, stay in S_OP.
  - S_OP, two-byte opcode accepted → S_EXT.
  - S_EXT, extension byte accepted → output register loaded, return to S_OP.
- Handshake:
  - INSTR_READY = ~DEC_VALID | DEC_READY, combinational, in both states.
  - A byte transfers when INSTR_VALID & INSTR_READY.
  - Output fields are registered. DEC_VALID rises the cycle after the final byte transfers.
  - DEC_VALID and all output fields hold stable while DEC_VALID & ~DEC_READY.
  - When the decoded instruction is consumed and the final byte of the next instruction transfers in the same cycle, DEC_VALID stays 1 and the fields update (back-to-back throughput of one instruction per final byte).
  - When the decoded instruction is consumed and no new instruction completes, DEC_VALID drops to 0 the next cycle.
  - An opcode byte in S_OP may transfer while an earlier instruction is being consumed.
- FLUSH:
  - Priority: below RST, above all else.
  - Next cycle: state = S_OP, DEC_VALID = 0.
  - Any byte presented in the flush cycle is discarded.
  - Data fields keep their last values.
- RST (also mid-instruction):
  - State = S_OP, DEC_VALID = 0, all data outputs 0.
  - Any latched first byte is lost.
- Data outputs are don't-care whenever DEC_VALID = 0.

Decomposition:
- Package decoder_pkg holds:
  - the opcode class constants (BR 3'b011, LDST 3'b111, F_LDST 2'b11);
  - the class encoding (CLS_ALU_R, CLS_ALU_I, CLS_BR, CLS_LDST);
  - the FSM state encoding (S_OP, S_EXT);
  - ALU_OP_LEN = 3 and REG_ID_LEN = 3.
- One combinational sub-module, instr_classify, maps an opcode byte to {class, needs_ext, ALU_OP, IMM_SEL, flags, REG_ID, short IMM}.
- The top level holds the FSM and the output register.

Test Plan (INSTR_LEN = 8, DATA_LEN = 8, PC_LEN = 8, ADDR_LEN = 8, DEC_READY = 1 unless stated):
1. Byte 0x45 → one cycle later DEC_VALID = 1, ALU_OP = 000, IMM_SEL = 1, IMM = 0x05.
2. Bytes 0x38 then 0x5A → DEC_VALID only after 0x5A; IS_BRN = 1, IS_BRZ = IS_BRP = 0, BR_TARGET = 0x5A; no DEC_VALID after 0x38 alone.
3. Bytes 0xD2 then 0xC3 → ALU_OP = 010, IMM_SEL = 1, IMM = 0xC3. Bytes 0xF3 then 0x80 → IS_LD = 1, ADDR_ABS = 1, REG_ID = 3, MEM_ADDR = 0x80.
4. Stream 0x45, 0x0B with DEC_READY = 0 for 3 cycles → first decode held for 3 cycles, INSTR_READY = 0, 0x0B not taken. Then DEC_READY = 1 → 0x0B decodes with ALU_OP = 001, IMM_SEL = 0, REG_ID = 3.
5. Byte 0x38, then FLUSH with 0x5A presented, then 0x45 → no branch decode is ever produced; next decode is the 0x45 immediate.
6. RST asserted while in S_EXT, then bytes 0x45, 0x22 (register ALU, one byte each) → both decode as one-byte instructions. Outputs read 0 and DEC_VALID = 0 during reset; a continuous stream sustains DEC_VALID = 1 every cycle.
